// File: rtl/serial_adder_if.sv
// serial_adder_if -- operand/result bundle for the bit-serial adder.
//   start            request to begin an operation (sampled while ready=1)
//   a, b             operands, WIDTH bits
//   in_carry         carry-in (add) / borrow-in (subtract)
//   subtract         0 = a+b+in_carry, 1 = a-b-in_carry
//   ready            adder idle and able to accept start
//   done             one-cycle pulse when a new result is presented
//   sum              registered result
//   out_carry        carry-out (add) / inverted borrow (subtract)
//   overflow         signed overflow of the last result
// master drives the request side; slave is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_carry;
  logic             subtract;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             out_carry;
  logic             overflow;

  modport master (
    output start, a, b, in_carry, subtract,
    input  ready, done, sum, out_carry, overflow
  );

  modport slave (
    input  start, a, b, in_carry, subtract,
    output ready, done, sum, out_carry, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial add/subtract, one bit per clock, LSB first.
//   clock    rising-edge clock for all state
//   reset_n  asynchronous active-low reset
//   bus      serial_adder_if.slave (start/a/b/in_carry/subtract in,
//            ready/done/sum/out_carry/overflow out)
//
// state | meaning
// IDLE  | ready=1, waiting for start; last result held on the outputs
// RUN   | one full-adder step per edge, WIDTH edges in total
// DONE  | done pulse cycle, returns to IDLE on the next edge
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] a_sr_q,    a_sr_d;
  logic [WIDTH-1:0] b_sr_q,    b_sr_d;
  logic [WIDTH-1:0] res_sr_q,  res_sr_d;
  logic             carry_q,   carry_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             cout_q,    cout_d;
  logic             ovf_q,     ovf_d;
  logic             done_q,    done_d;

  logic             fa_a, fa_b, fa_s, fa_c;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    fa_a = a_sr_q[0];
    fa_b = b_sr_q[0];
    fa_s = fa_a ^ fa_b ^ carry_q;
    fa_c = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
    // Shift written this way so WIDTH=1 needs no special case.
    res_shift            = res_sr_q >> 1;
    res_shift[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          // Subtract as a + ~b + 1; a borrow-in removes that +1.
          b_sr_d  = bus.subtract ? ~bus.b : bus.b;
          carry_d = bus.in_carry ^ bus.subtract;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_shift;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = res_shift;
          cout_d  = fa_c;
          // carry_q is the carry into the MSB stage on this edge.
          ovf_d   = carry_q ^ fa_c;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.out_carry = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- scoreboard bench for serial_adder at WIDTH 8, 1 and 16.
// Index 0/1/2 selects the WIDTH 8/1/16 instance throughout.
module tb_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ov;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t        sb [3][$];
  logic [15:0] last_s [3];
  logic        prev_done [3];
  int          wid [3] = '{8, 1, 16};

  logic [15:0] va8  [8] = '{16'h00, 16'h0F, 16'hFF, 16'h7F, 16'h01, 16'h07, 16'h05, 16'h80};
  logic [15:0] vb8  [8] = '{16'h00, 16'h01, 16'h01, 16'h01, 16'h01, 16'h05, 16'h07, 16'h01};
  logic [15:0] va16 [8] = '{16'h0000, 16'h000F, 16'hFFFF, 16'h7FFF, 16'h0001, 16'h0007, 16'h0005, 16'h8000};
  logic [15:0] vb16 [8] = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0007, 16'h0001};
  logic [7:0]  v_ci  = 8'b0001_0000;
  logic [7:0]  v_sub = 8'b1110_0000;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(1))  bus1 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();

  serial_adder #(.WIDTH(8))  dut8  (.clock(clock), .reset_n(reset_n), .bus(bus8));
  serial_adder #(.WIDTH(1))  dut1  (.clock(clock), .reset_n(reset_n), .bus(bus1));
  serial_adder #(.WIDTH(16)) dut16 (.clock(clock), .reset_n(reset_n), .bus(bus16));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_op(int w, logic [15:0] av, logic [15:0] bv, logic ci, logic sub);
    exp_t   e;
    longint m, half, ua, ub, sa, sbv, r, sr;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & m;
    ub   = longint'(bv) & m;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sbv  = (ub >= half) ? ub - (m + 1) : ub;
    if (sub) begin
      r    = ua - ub - longint'(ci);
      sr   = sa - sbv - longint'(ci);
      e.co = (r >= 0);
    end else begin
      r    = ua + ub + longint'(ci);
      sr   = sa + sbv + longint'(ci);
      e.co = (r > m);
    end
    e.sum = 16'(r & m);
    e.ov  = (sr >= half) || (sr < -half);
    e.cyc = 0;
    return e;
  endfunction

  task automatic set_in(int i, logic st, logic [15:0] av, logic [15:0] bv, logic ci, logic sub);
    case (i)
      0: begin bus8.start = st;  bus8.a = av[7:0]; bus8.b = bv[7:0];
               bus8.in_carry = ci; bus8.subtract = sub; end
      1: begin bus1.start = st;  bus1.a = av[0:0]; bus1.b = bv[0:0];
               bus1.in_carry = ci; bus1.subtract = sub; end
      default: begin bus16.start = st; bus16.a = av; bus16.b = bv;
               bus16.in_carry = ci; bus16.subtract = sub; end
    endcase
  endtask

  function automatic logic get_ready(int i);
    case (i)
      0:       return bus8.ready;
      1:       return bus1.ready;
      default: return bus16.ready;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(int i);
    case (i)
      0:       return {8'h00, bus8.sum};
      1:       return {15'h0000, bus1.sum};
      default: return bus16.sum;
    endcase
  endfunction

  // Called away from the clock edge; returns 1 ns after the accepting edge.
  task automatic do_op(int i, logic [15:0] av, logic [15:0] bv, logic ci, logic sub, bit push);
    int   n;
    int   acc;
    exp_t e;
    n = 0;
    while (!get_ready(i) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk($sformatf("ready_timeout%0d", wid[i]), 32'(get_ready(i)), 32'd1);
    set_in(i, 1'b1, av, bv, ci, sub);
    @(posedge clock);
    #1;
    acc = cyc;
    set_in(i, 1'b0, av, bv, ci, sub);
    chk($sformatf("busy%0d", wid[i]), 32'(get_ready(i)), 32'd0);
    chk($sformatf("hold%0d", wid[i]), 32'(get_sum(i)), 32'(last_s[i]));
    if (push) begin
      e     = ref_op(wid[i], av, bv, ci, sub);
      e.cyc = acc + wid[i];
      sb[i].push_back(e);
    end
  endtask

  task automatic drain(int i);
    int n;
    n = 0;
    while (sb[i].size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("drain%0d", wid[i]), 32'(sb[i].size()), 32'd0);
  endtask

  task automatic mon(int i, logic dn, logic [15:0] s, logic co, logic ov);
    exp_t e;
    if (dn) begin
      chk($sformatf("done_double%0d", wid[i]), 32'(prev_done[i]), 32'd0);
      if (sb[i].size() == 0) begin
        chk($sformatf("done_spurious%0d", wid[i]), 32'(dn), 32'd0);
      end else begin
        e = sb[i].pop_front();
        chk($sformatf("sum%0d", wid[i]), 32'(s), 32'(e.sum));
        chk($sformatf("carry%0d", wid[i]), 32'(co), 32'(e.co));
        chk($sformatf("ovf%0d", wid[i]), 32'(ov), 32'(e.ov));
        chk($sformatf("latency%0d", wid[i]), 32'(cyc), 32'(e.cyc));
        last_s[i] = e.sum;
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      mon(0, bus8.done,  {8'h00, bus8.sum},     bus8.out_carry,  bus8.overflow);
      mon(1, bus1.done,  {15'h0000, bus1.sum},  bus1.out_carry,  bus1.overflow);
      mon(2, bus16.done, bus16.sum,             bus16.out_carry, bus16.overflow);
    end
    prev_done[0] <= bus8.done;
    prev_done[1] <= bus1.done;
    prev_done[2] <= bus16.done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lowcnt;
    for (int i = 0; i < 3; i++) begin
      last_s[i]    = '0;
      prev_done[i] = 1'b0;
      set_in(i, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    end

    // Reset and idle outputs
    reset_n = 1'b0;
    #23;
    chk("rst_ready", 32'(bus8.ready), 32'd1);
    chk("rst_done",  32'(bus8.done), 32'd0);
    chk("rst_sum",   32'(bus8.sum), 32'd0);
    chk("rst_carry", 32'(bus8.out_carry), 32'd0);
    chk("rst_ovf",   32'(bus8.overflow), 32'd0);
    chk("rst_sum16", 32'(bus16.sum), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_ready", 32'(bus8.ready), 32'd1);
    chk("idle_done",  32'(bus8.done), 32'd0);

    // WIDTH=8 vector table: zero, add cases, subtract cases
    for (int k = 0; k < 8; k++) begin
      do_op(0, va8[k], vb8[k], v_ci[k], v_sub[k], 1'b1);
      drain(0);
    end

    // Reset after 4 RUN edges of 0xFF+0x01
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus8.ready), 32'd1);
    chk("midrst_done",  32'(bus8.done), 32'd0);
    chk("midrst_sum",   32'(bus8.sum), 32'd0);
    chk("midrst_carry", 32'(bus8.out_carry), 32'd0);
    chk("midrst_ovf",   32'(bus8.overflow), 32'd0);
    for (int i = 0; i < 3; i++) last_s[i] = '0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    do_op(0, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
    drain(0);
    repeat (12) @(negedge clock);

    // Start pulses and operand churn while busy
    do_op(0, 16'h005A, 16'h0033, 1'b1, 1'b0, 1'b1);
    lowcnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (bus8.ready) break;
      lowcnt++;
      set_in(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("ready_low_cycles", 32'(lowcnt), 32'd9);
    drain(0);
    repeat (12) @(negedge clock);
    chk("churn_no_extra", 32'(sb[0].size()), 32'd0);

    // WIDTH=1 and WIDTH=16 vector tables plus random vectors
    for (int k = 0; k < 8; k++) begin
      do_op(1, va8[k], vb8[k], v_ci[k], v_sub[k], 1'b1);
      drain(1);
      do_op(2, va16[k], vb16[k], v_ci[k], v_sub[k], 1'b1);
      drain(2);
    end
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) begin
        do_op(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1);
        drain(i);
      end
    end

    repeat (4) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be supported for any WIDTH >= 1.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only when ready=1.
REQ-005 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-006 b  input  WIDTH  operand B.
REQ-007 in_carry  input  1  carry-in for add; borrow-in for subtract.
REQ-008 subtract  input  1  0 = A+B+in_carry; 1 = A-B-in_carry.
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 done  output  1  single-cycle pulse marking a new result.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 out_carry  output  1  carry-out for add; inverted borrow for subtract (1 = no borrow).
REQ-013 overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The block SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 In IDLE, ready SHALL be 1; in RUN and DONE, ready SHALL be 0.
REQ-016 start=1 in IDLE SHALL, at that edge, latch a into the A shift register and latch b into the B shift register (b inverted bitwise when subtract=1).
REQ-017 At the same edge, the carry flip-flop SHALL load in_carry XOR subtract, clear the bit counter, and enter RUN.
REQ-018 In RUN, each edge SHALL process one bit, LSB first, through a one-bit full-adder stage: bit = a_i XOR b_i XOR c; c_next = majority(a_i, b_i, c).
REQ-019 Each RUN edge SHALL shift the sum bit into the result shift register MSB end and increment the bit counter.
REQ-020 The counter SHALL be sized to hold WIDTH without wrap; RUN SHALL last exactly WIDTH edges.
REQ-021 On the WIDTH-th RUN edge, the block SHALL load the completed result into sum, the final carry into out_carry, and the MSB-stage carry-in XOR final carry into overflow.
REQ-022 On the same WIDTH-th RUN edge, the block SHALL set done=1 and enter DONE.
REQ-023 DONE SHALL last one cycle, clear done, and return to IDLE; done SHALL never be high for more than one consecutive cycle.
REQ-024 Latency SHALL be exactly WIDTH edges from the accepting edge to done rising; a new start is accepted no earlier than WIDTH+2 edges after the previous acceptance.
REQ-025 sum, out_carry and overflow SHALL hold their last result unchanged through later IDLE and RUN cycles until the next completion.
REQ-026 start while ready=0 (RUN or DONE) SHALL be ignored with no effect on state or results.
REQ-027 a, b, in_carry and subtract changes after the accepting edge SHALL NOT affect the operation in progress.
REQ-028 WIDTH=1 SHALL complete in one RUN edge; overflow then equals in_carry XOR subtract XOR out_carry.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, ready=1, done=0, sum=0, out_carry=0, overflow=0, and clear all shift registers, the counter and the carry flip-flop.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation; no done pulse SHALL follow the reset release.
REQ-031 After reset_n returns to 1, start SHALL be accepted on the first rising edge.

Verification (WIDTH=8 unless stated)
REQ-032 Reset then idle: ready=1, done=0, sum=0x00, out_carry=0, overflow=0; 0x00+0x00, cin=0 -> sum=0x00, carry=0, done exactly 8 edges after acceptance.
REQ-033 Add cases: 0x0F+0x01 -> 0x10, c=0, ovf=0; 0xFF+0x01 -> 0x00, c=1, ovf=0; 0x7F+0x01 -> 0x80, c=0, ovf=1; 0x01+0x01, cin=1 -> 0x03.
REQ-034 Subtract cases: 0x07-0x05 -> 0x02, out_carry=1; 0x05-0x07 -> 0xFE, out_carry=0; 0x80-0x01 -> 0x7F, ovf=1.
REQ-035 Pulse start and change a/b every cycle during RUN and DONE: result matches the first accepted operands, one done pulse only, ready low for exactly 9 cycles.
REQ-036 Assert reset_n=0 for one cycle after 4 RUN edges of 0xFF+0x01: all outputs zero immediately, no done follows, and the next 0x02+0x03 gives 0x05.
REQ-037 Repeat REQ-033 vectors with WIDTH=1 and WIDTH=16 (e.g. 0xFFFF+0x0001 -> 0x0000, c=1); compare every result against a behavioural (a +/- b +/- cin) reference model.
